// File: rtl/perf_pkg.sv
// Shared types and constants for the performance counter bank.
package perf_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } perf_state_e;

  localparam int PERF_WRAP = 0;
  localparam int PERF_SAT  = 1;

  // Channel assignment used by proc_hier (valid when NUM_CH >= 5).
  localparam int CH_INST  = 1;
  localparam int CH_ICREQ = 2;
  localparam int CH_ICHIT = 3;
  localparam int CH_DCREQ = 4;
  localparam int CH_DCHIT = 5;

endpackage

// File: rtl/perf_ctr.sv
// Single event counter with freeze, synchronous clear and a sticky overflow
// flag; wraps or saturates depending on SAT_MODE.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int SAT_MODE = PERF_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  input  logic             frz,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc && !frz) begin
      if (cnt_q == CNT_MAX) begin
        // Saturating counters keep max; wrapping ones roll to zero.
        ovf_d = 1'b1;
        if (SAT_MODE != PERF_SAT) begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Cycle counter plus NUM_CH event counters, with a polled read port and a
// valid/ready dump stream of all counts once the core halts.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  CNT_W    = 32,
  parameter int  SAT_MODE = PERF_WRAP,
  localparam int IDX_W    = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [NUM_CH-1:0] evt,
  input  logic              halt,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_sel,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH:0]   ovf,
  output logic              frozen,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [IDX_W-1:0]  dump_idx,
  output logic [CNT_W-1:0]  dump_data,
  output logic              dump_last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

  perf_state_e      state_q, state_d;
  logic             halt_q, halt_d;
  logic             halt_rise;
  logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             dump_fire;
  logic [NUM_CH:0]  inc_vec;
  logic [CNT_W-1:0] cnt [NUM_CH+1];

  // Bit 0 is the cycle counter; bits 1..NUM_CH follow the event inputs.
  assign inc_vec   = {evt & {NUM_CH{enable}}, enable};
  assign halt_d    = halt;
  assign halt_rise = halt & ~halt_q;
  assign dump_fire = dump_valid & dump_ready;

  for (genvar gi = 0; gi <= NUM_CH; gi++) begin : g_ctr
    perf_ctr #(
      .CNT_W   (CNT_W),
      .SAT_MODE(SAT_MODE)
    ) u_ctr (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (inc_vec[gi]),
      .clr  (clear),
      .frz  (frozen),
      .cnt  (cnt[gi]),
      .ovf  (ovf[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_rise) state_d = DUMP;
      DUMP:    if (dump_fire && dump_last) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
    if (clear) begin
      state_d = RUN;
    end
  end

  always_comb begin
    frozen     = (state_q != RUN);
    dump_valid = (state_q == DUMP);
    dump_last  = dump_valid && (dump_idx_q == LAST_IDX);
  end

  // Held at zero while running so the first DUMP beat is always index 0.
  always_comb begin
    dump_idx_d = dump_idx_q;
    if (clear || state_q == RUN) begin
      dump_idx_d = '0;
    end else if (dump_fire && !dump_last) begin
      dump_idx_d = dump_idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;
    if (rd_req) begin
      if (rd_sel <= LAST_IDX) begin
        rd_data_d = cnt[rd_sel];
      end else begin
        rd_data_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q     <= 1'b0;
      dump_idx_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      halt_q     <= halt_d;
      dump_idx_q <= dump_idx_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign dump_idx  = dump_idx_q;
  assign dump_data = cnt[dump_idx_q];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Lockstep check of a wrapping and a saturating 8-bit bank against a
// cycle-level behavioural model of counts, reads and the dump sequence.
module tb_perf_counter_bank;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 3;
  localparam int NDUT   = 2;  // 0: wrapping, 1: saturating
  localparam int unsigned CMAX = 255;

  logic              clk = 1'b0;
  logic              rst_n, enable, clear, halt, rd_req, dump_ready;
  logic [NUM_CH-1:0] evt;
  logic [IDX_W-1:0]  rd_sel;

  logic              rd_valid   [NDUT];
  logic [CNT_W-1:0]  rd_data    [NDUT];
  logic [NUM_CH:0]   ovf        [NDUT];
  logic              frozen     [NDUT];
  logic              dump_valid [NDUT];
  logic [IDX_W-1:0]  dump_idx   [NDUT];
  logic [CNT_W-1:0]  dump_data  [NDUT];
  logic              dump_last  [NDUT];

  always #5 clk = ~clk;

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT_MODE(0)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .evt(evt), .halt(halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
    .ovf(ovf[0]), .frozen(frozen[0]), .dump_valid(dump_valid[0]), .dump_ready(dump_ready),
    .dump_idx(dump_idx[0]), .dump_data(dump_data[0]), .dump_last(dump_last[0])
  );

  perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SAT_MODE(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .evt(evt), .halt(halt),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
    .ovf(ovf[1]), .frozen(frozen[1]), .dump_valid(dump_valid[1]), .dump_ready(dump_ready),
    .dump_idx(dump_idx[1]), .dump_data(dump_data[1]), .dump_last(dump_last[1])
  );

  // Behavioural model
  int unsigned     m_cnt [NDUT][NUM_CH+1];
  bit [NUM_CH:0]   m_ovf [NDUT];
  int unsigned     m_rd_data [NDUT];
  bit              m_rd_valid;
  int              m_rd_sel;
  bit              m_frozen;
  int              m_beat;     // next dump beat; > NUM_CH once the dump is complete
  bit              m_halt_prev;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic model_zero_counts();
    for (int k = 0; k < NDUT; k++) begin
      m_ovf[k] = '0;
      for (int i = 0; i <= NUM_CH; i++) m_cnt[k][i] = 0;
    end
  endtask

  task automatic model_reset();
    model_zero_counts();
    for (int k = 0; k < NDUT; k++) m_rd_data[k] = 0;
    m_rd_valid  = 1'b0;
    m_rd_sel    = 0;
    m_frozen    = 1'b0;
    m_beat      = 0;
    m_halt_prev = 1'b0;
  endtask

  // One event on counter i of bank k; k=0 counts modulo 2^CNT_W, k=1 clamps.
  task automatic model_event(input int k, input int i);
    if (k == 0) begin
      m_cnt[k][i] = (m_cnt[k][i] + 1) % (CMAX + 1);
      if (m_cnt[k][i] == 0) m_ovf[k][i] = 1'b1;
    end else if (m_cnt[k][i] + 1 > CMAX) begin
      m_ovf[k][i] = 1'b1;
    end else begin
      m_cnt[k][i] = m_cnt[k][i] + 1;
    end
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_edge();
    bit fire;
    logic [NUM_CH:0] evt_ext;
    evt_ext = {evt, 1'b1};
    fire = m_frozen && (m_beat <= NUM_CH) && dump_ready;
    if (fire)
      $display("dump beat idx=%0d wrap=%0d sat=%0d last=%0d", m_beat,
               m_cnt[0][m_beat], m_cnt[1][m_beat], (m_beat == NUM_CH));
    m_rd_valid = rd_req;
    if (rd_req) begin
      m_rd_sel = int'(rd_sel);
      for (int k = 0; k < NDUT; k++)
        m_rd_data[k] = (int'(rd_sel) <= NUM_CH) ? m_cnt[k][rd_sel] : 0;
    end
    if (clear) begin
      model_zero_counts();
      m_frozen = 1'b0;
      m_beat   = 0;
    end else if (!m_frozen) begin
      if (enable)
        for (int k = 0; k < NDUT; k++)
          for (int i = 0; i <= NUM_CH; i++)
            if (evt_ext[i]) model_event(k, i);
      if (halt && !m_halt_prev) begin
        m_frozen = 1'b1;
        m_beat   = 0;
      end
    end else if (fire) begin
      m_beat++;
    end
    m_halt_prev = halt;
  endtask

  task automatic check_outputs();
    bit exp_dv;
    exp_dv = m_frozen && (m_beat <= NUM_CH);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rd_valid_%0d", k), 64'(rd_valid[k]), 64'(m_rd_valid));
      chk($sformatf("rd_data_%0d", k), 64'(rd_data[k]), 64'(m_rd_data[k]));
      chk($sformatf("ovf_%0d", k), 64'(ovf[k]), 64'(m_ovf[k]));
      chk($sformatf("frozen_%0d", k), 64'(frozen[k]), 64'(m_frozen));
      chk($sformatf("dump_valid_%0d", k), 64'(dump_valid[k]), 64'(exp_dv));
      chk($sformatf("dump_last_%0d", k), 64'(dump_last[k]), 64'(exp_dv && (m_beat == NUM_CH)));
      if (exp_dv) begin
        chk($sformatf("dump_idx_%0d", k), 64'(dump_idx[k]), 64'(m_beat));
        chk($sformatf("dump_data_%0d", k), 64'(dump_data[k]), 64'(m_cnt[k][m_beat]));
      end else if (!m_frozen) begin
        chk($sformatf("dump_idx_idle_%0d", k), 64'(dump_idx[k]), 64'(0));
      end
    end
    if (m_rd_valid)
      $display("read sel=%0d wrap=%0d sat=%0d", m_rd_sel, rd_data[0], rd_data[1]);
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic read_expect(input int sel, input int unsigned exp_wrap, input int unsigned exp_sat);
    rd_req = 1'b1;
    rd_sel = IDX_W'(sel);
    cycle();
    rd_req = 1'b0;
    chk($sformatf("lit_rd%0d_wrap", sel), 64'(rd_data[0]), 64'(exp_wrap));
    chk($sformatf("lit_rd%0d_sat", sel), 64'(rd_data[1]), 64'(exp_sat));
  endtask

  // Pulse rst_n between edges and check outputs before any clock arrives.
  task automatic async_reset_pulse();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int k = 0; k < NDUT; k++)
      chk($sformatf("rst_dump_data_%0d", k), 64'(dump_data[k]), 64'(0));
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int  budget;
    bit  rdy;

    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; halt = 1'b0;
    rd_req = 1'b0; rd_sel = '0; dump_ready = 1'b0; evt = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;

    // Basic counting
    enable = 1'b1; evt = 4'b0101;
    repeat (10) cycle();
    enable = 1'b0; evt = '0;
    read_expect(0, 10, 10);
    read_expect(1, 10, 10);
    read_expect(2, 0, 0);
    read_expect(3, 10, 10);
    read_expect(4, 0, 0);
    read_expect(5, 0, 0);
    read_expect(7, 0, 0);
    chk("lit_ovf_after_count", 64'(ovf[0]), 64'(0));

    // Wrap versus saturate over 257 events
    clear = 1'b1; cycle(); clear = 1'b0;
    enable = 1'b1; evt = 4'b0001;
    repeat (257) cycle();
    enable = 1'b0; evt = '0;
    read_expect(0, 1, 255);
    read_expect(1, 1, 255);
    read_expect(2, 0, 0);
    chk("lit_ovf_wrap", 64'(ovf[0]), 64'(5'b00011));
    chk("lit_ovf_sat", 64'(ovf[1]), 64'(5'b00011));

    // Halt dump with alternating backpressure
    clear = 1'b1; cycle(); clear = 1'b0;
    enable = 1'b1; evt = 4'b0010;
    repeat (20) cycle();
    halt = 1'b1;
    cycle();
    chk("lit_frozen_after_halt", 64'(frozen[0]), 64'(1));
    budget = 40;
    rdy = 1'b0;
    while (m_frozen && (m_beat <= NUM_CH) && budget > 0) begin
      dump_ready = rdy;
      rdy = !rdy;
      cycle();
      budget--;
    end
    dump_ready = 1'b0;
    chk("lit_dump_ended", 64'(dump_valid[0]), 64'(0));
    repeat (5) cycle();
    read_expect(0, 21, 21);
    read_expect(2, 21, 21);
    read_expect(1, 0, 0);

    // Clear leaves DONE; held halt must not re-trigger
    clear = 1'b1; cycle(); clear = 1'b0;
    chk("lit_run_after_clear", 64'(frozen[0]), 64'(0));
    repeat (5) cycle();
    halt = 1'b0; cycle();
    halt = 1'b1; cycle();
    dump_ready = 1'b1;
    budget = 10;
    while (!(dump_valid[0] === 1'b1 && dump_idx[0] == 3'd2) && budget > 0) begin
      cycle();
      budget--;
    end
    chk("wait_dump_idx2", 64'(dump_idx[0]), 64'(2));
    clear = 1'b1; cycle(); clear = 1'b0;
    chk("lit_dump_aborted", 64'(dump_valid[0]), 64'(0));
    read_expect(0, 0, 0);
    repeat (4) cycle();
    chk("lit_no_retrigger", 64'(frozen[1]), 64'(0));
    halt = 1'b0; dump_ready = 1'b0;

    // clear, halt edge and events in one cycle; then read during increment
    enable = 1'b0; evt = '0;
    cycle();
    clear = 1'b1; halt = 1'b1; evt = '1; enable = 1'b1;
    cycle();
    clear = 1'b0; halt = 1'b0; evt = '0; enable = 1'b0;
    chk("lit_simul_no_dump", 64'(frozen[0]), 64'(0));
    chk("lit_simul_ovf", 64'(ovf[1]), 64'(0));
    read_expect(4, 0, 0);
    enable = 1'b1; evt = '1;
    read_expect(3, 0, 0);
    read_expect(3, 1, 1);
    enable = 1'b0; evt = '0;

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      enable     = ($urandom_range(0, 3) != 0);
      evt        = NUM_CH'($urandom);
      clear      = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 39) == 0) halt = !halt;
      rd_req     = $urandom_range(0, 1) != 0;
      rd_sel     = IDX_W'($urandom_range(0, 7));
      dump_ready = $urandom_range(0, 1) != 0;
      cycle();
    end
    rd_req = 1'b0; halt = 1'b0; dump_ready = 1'b0;

    // Asynchronous reset in the middle of a dump
    clear = 1'b1; cycle(); clear = 1'b0;
    enable = 1'b1; evt = 4'b1010;
    repeat (5) cycle();
    halt = 1'b1; cycle();
    cycle();
    chk("lit_in_dump", 64'(dump_valid[0]), 64'(1));
    halt = 1'b0;
    async_reset_pulse();
    enable = 1'b1; evt = 4'b1111;
    repeat (6) cycle();
    enable = 1'b0; evt = '0;
    read_expect(0, 6, 6);
    read_expect(4, 6, 6);

    // halt already high when reset releases dumps on the first clock
    halt = 1'b1;
    async_reset_pulse();
    cycle();
    chk("lit_halt_from_reset", 64'(dump_valid[0]), 64'(1));
    dump_ready = 1'b1;
    repeat (NUM_CH + 2) cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    halt = 1'b0; dump_ready = 1'b0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
